// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN classifier pipeline stages.
package cnn_pkg;

  localparam int unsigned NUM_CLASSES_DEFAULT = 10;
  localparam int unsigned SCORE_W_DEFAULT     = 32;
  localparam int unsigned SCORE_W_MAX         = 64;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } argmax_state_t;

  // Operands arrive already sign- or zero-extended to SCORE_W_MAX bits.
  function automatic logic score_gt(input logic [SCORE_W_MAX-1:0] a,
                                    input logic [SCORE_W_MAX-1:0] b,
                                    input logic                   signed_mode);
    if (signed_mode) return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/argmax_stream_topk2_tracker.sv
// One-beat combinational update of the best/second-best score pair and best index.
module topk2_tracker
  import cnn_pkg::*;
#(
  parameter int unsigned SCORE_W     = SCORE_W_DEFAULT,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned SIGNED_MODE = 0
) (
  input  logic               first_beat,
  input  logic [SCORE_W-1:0] score,
  input  logic [IDX_W-1:0]   idx,
  input  logic [SCORE_W-1:0] best,
  input  logic [SCORE_W-1:0] second,
  input  logic [IDX_W-1:0]   best_idx,
  output logic [SCORE_W-1:0] best_c,
  output logic [SCORE_W-1:0] second_c,
  output logic [IDX_W-1:0]   best_idx_c
);

  localparam logic SGN = (SIGNED_MODE != 0);
  localparam logic [SCORE_W-1:0] MIN_SCORE =
    SGN ? {1'b1, {(SCORE_W-1){1'b0}}} : '0;

  function automatic logic [SCORE_W_MAX-1:0] ext(input logic [SCORE_W-1:0] v);
    if (SGN) return SCORE_W_MAX'($signed(v));
    return SCORE_W_MAX'(v);
  endfunction

  logic gt_best;
  logic gt_second;

  assign gt_best   = score_gt(ext(score), ext(best), SGN);
  assign gt_second = score_gt(ext(score), ext(second), SGN);

  // Strict compares keep the lower index on ties.
  always_comb begin
    best_c     = best;
    second_c   = second;
    best_idx_c = best_idx;
    if (first_beat) begin
      best_c     = score;
      best_idx_c = '0;
      second_c   = MIN_SCORE;
    end else if (gt_best) begin
      second_c   = best;
      best_c     = score;
      best_idx_c = idx;
    end else if (gt_second) begin
      second_c   = score;
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: scans one class score per beat, reports winner, top score and margin per frame.
module argmax_stream
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEFAULT,
  parameter int unsigned SCORE_W     = SCORE_W_DEFAULT,
  parameter int unsigned SIGNED_MODE = 0,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_class,
  output logic [SCORE_W-1:0] out_score,
  output logic [SCORE_W:0]   out_margin,
  output logic               out_error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  function automatic logic [SCORE_W:0] widen(input logic [SCORE_W-1:0] v);
    return (SIGNED_MODE != 0) ? {v[SCORE_W-1], v} : {1'b0, v};
  endfunction

  argmax_state_t      state_q, state_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [SCORE_W-1:0] second_q, second_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   out_class_q, out_class_d;
  logic [SCORE_W-1:0] out_score_q, out_score_d;
  logic [SCORE_W:0]   out_margin_q, out_margin_d;
  logic               out_error_q, out_error_d;

  logic [SCORE_W-1:0] best_c;
  logic [SCORE_W-1:0] second_c;
  logic [IDX_W-1:0]   best_idx_c;
  logic               accept_c;
  logic               at_last_c;

  topk2_tracker #(
    .SCORE_W    (SCORE_W),
    .IDX_W      (IDX_W),
    .SIGNED_MODE(SIGNED_MODE)
  ) u_tracker (
    .first_beat(count_q == '0),
    .score     (in_score),
    .idx       (count_q),
    .best      (best_q),
    .second    (second_q),
    .best_idx  (best_idx_q),
    .best_c    (best_c),
    .second_c  (second_c),
    .best_idx_c(best_idx_c)
  );

  assign accept_c  = in_valid && in_ready_q;
  assign at_last_c = (count_q == LAST_IDX);

  // Next-state and output-register logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    best_d       = best_q;
    second_d     = second_q;
    best_idx_d   = best_idx_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
    out_margin_d = out_margin_q;
    out_error_d  = out_error_q;
    unique case (state_q)
      ACCUM: begin
        if (accept_c) begin
          best_d     = best_c;
          second_d   = second_c;
          best_idx_d = best_idx_c;
          count_d    = count_q + IDX_W'(1);
          if (in_last || at_last_c) begin
            count_d      = '0;
            state_d      = HOLD;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            out_class_d  = best_idx_c;
            out_score_d  = best_c;
            out_margin_d = widen(best_c) - widen(second_c);
            out_error_d  = (in_last != at_last_c);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      count_q      <= '0;
      best_q       <= '0;
      second_q     <= '0;
      best_idx_q   <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_class_q  <= '1;
      out_score_q  <= '0;
      out_margin_q <= '0;
      out_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      best_q       <= best_d;
      second_q     <= second_d;
      best_idx_q   <= best_idx_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
      out_margin_q <= out_margin_d;
      out_error_q  <= out_error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_score  = out_score_q;
  assign out_margin = out_margin_q;
  assign out_error  = out_error_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: unsigned and signed instances share one stimulus stream.
module tb_argmax_stream;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_score = '0;

  logic          in_ready_u, out_valid_u, out_error_u;
  logic [IW-1:0] out_class_u;
  logic [W-1:0]  out_score_u;
  logic [W:0]    out_margin_u;
  logic          in_ready_s, out_valid_s, out_error_s;
  logic [IW-1:0] out_class_s;
  logic [W-1:0]  out_score_s;
  logic [W:0]    out_margin_s;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  argmax_stream #(.NUM_CLASSES(N), .SCORE_W(W), .SIGNED_MODE(0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_score(in_score), .in_last(in_last), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_class(out_class_u), .out_score(out_score_u),
    .out_margin(out_margin_u), .out_error(out_error_u)
  );

  argmax_stream #(.NUM_CLASSES(N), .SCORE_W(W), .SIGNED_MODE(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_score(in_score), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_class(out_class_s), .out_score(out_score_s),
    .out_margin(out_margin_s), .out_error(out_error_s)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: frame contents, handshake state and expected output fields (index 0 unsigned, 1 signed).
  logic [W-1:0]  beats[$];
  logic          m_in_ready = 1'b1;
  logic          m_out_valid = 1'b0;
  logic [IW-1:0] m_cls[2];
  logic [W-1:0]  m_score[2];
  logic [W:0]    m_margin[2];
  logic          m_err[2];

  function automatic longint val(input logic [W-1:0] b, input int sm);
    if (sm != 0) return longint'($signed(b));
    return longint'({32'b0, b});
  endfunction

  task automatic model_reset();
    beats.delete();
    m_in_ready = 1'b1;
    m_out_valid = 1'b0;
    for (int sm = 0; sm < 2; sm++) begin
      m_cls[sm] = '1; m_score[sm] = '0; m_margin[sm] = '0; m_err[sm] = 1'b0;
    end
  endtask

  task automatic model_close(input logic err);
    for (int sm = 0; sm < 2; sm++) begin
      longint mx, sec;
      int idx;
      mx = val(beats[0], sm);
      foreach (beats[i]) if (val(beats[i], sm) > mx) mx = val(beats[i], sm);
      idx = 0;
      for (int i = beats.size() - 1; i >= 0; i--) if (val(beats[i], sm) == mx) idx = i;
      sec = (sm != 0) ? -64'sd2147483648 : 64'sd0;
      if (beats.size() > 1) begin
        bit first = 1;
        foreach (beats[i]) if (i != idx) begin
          if (first || val(beats[i], sm) > sec) sec = val(beats[i], sm);
          first = 0;
        end
      end
      m_cls[sm]    = IW'(idx);
      m_score[sm]  = beats[idx];
      m_margin[sm] = 33'(mx - sec);
      m_err[sm]    = err;
    end
    beats.delete();
  endtask

  initial model_reset();

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) model_reset();
    else if (m_in_ready && in_valid) begin
      beats.push_back(in_score);
      if (in_last || beats.size() == N) begin
        model_close(!(in_last && beats.size() == N));
        m_in_ready = 1'b0;
        m_out_valid = 1'b1;
      end
    end else if (m_out_valid && out_ready) begin
      m_out_valid = 1'b0;
      m_in_ready = 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready_u", 64'(in_ready_u), 64'(m_in_ready));
      chk("out_valid_u", 64'(out_valid_u), 64'(m_out_valid));
      chk("out_class_u", 64'(out_class_u), 64'(m_cls[0]));
      chk("out_score_u", 64'(out_score_u), 64'(m_score[0]));
      chk("out_margin_u", 64'(out_margin_u), 64'(m_margin[0]));
      chk("out_error_u", 64'(out_error_u), 64'(m_err[0]));
      chk("in_ready_s", 64'(in_ready_s), 64'(m_in_ready));
      chk("out_valid_s", 64'(out_valid_s), 64'(m_out_valid));
      chk("out_class_s", 64'(out_class_s), 64'(m_cls[1]));
      chk("out_score_s", 64'(out_score_s), 64'(m_score[1]));
      chk("out_margin_s", 64'(out_margin_s), 64'(m_margin[1]));
      chk("out_error_s", 64'(out_error_s), 64'(m_err[1]));
    end
  end

  logic [W-1:0] fr[$];

  task automatic send_beat(input logic [W-1:0] s, input logic last);
    int g = 0;
    in_valid = 1'b1; in_score = s; in_last = last;
    while (!in_ready_u && g < 100) begin @(negedge clk); g++; end
    chk("in_ready_wait", 64'(in_ready_u), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input int gap_max);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max)) @(negedge clk);
      send_beat(fr[i], i == last_at);
    end
  endtask

  task automatic consume(input int stall);
    int g = 0;
    while (!out_valid_u && g < 100) begin @(negedge clk); g++; end
    chk("out_valid_wait", 64'(out_valid_u), 64'd1);
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    lit("reset_class", 64'(out_class_u), 64'hF);
    lit("reset_in_ready", 64'(in_ready_u), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame: out_valid one cycle after the last beat.
    fr = '{32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd0, 32'd5, 32'd4, 32'd8, 32'd6};
    send_frame(10, 9, 0);
    lit("t1_latency", 64'(out_valid_u), 64'd1);
    lit("t1_class", 64'(out_class_u), 64'd1);
    lit("t1_score", 64'(out_score_u), 64'd9);
    lit("t1_margin", 64'(out_margin_u), 64'd1);
    lit("t1_error", 64'(out_error_u), 64'd0);
    consume(2);

    fr = '{32'd5, 32'd12, 32'd12, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    send_frame(10, 9, 1);
    lit("tie_class", 64'(out_class_u), 64'd1);
    lit("tie_margin", 64'(out_margin_u), 64'd0);
    consume(0);

    fr = '{-32'd5, -32'd2, -32'd9, -32'd3, -32'd7, -32'd8, -32'd6, -32'd4, -32'd10, -32'd11};
    send_frame(10, 9, 0);
    lit("signed_class", 64'(out_class_s), 64'd1);
    lit("signed_score", 64'(out_score_s), 64'hFFFF_FFFE);
    lit("signed_margin", 64'(out_margin_s), 64'd1);
    consume(1);

    fr = '{32'd4, 32'd2, 32'd6, 32'd1};
    send_frame(4, 3, 0);
    lit("short_error", 64'(out_error_u), 64'd1);
    lit("short_class", 64'(out_class_u), 64'd2);
    lit("short_margin", 64'(out_margin_u), 64'd2);
    consume(0);
    fr = '{32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd0, 32'd5, 32'd4, 32'd8, 32'd6};
    send_frame(10, 9, 0);
    lit("after_short_error", 64'(out_error_u), 64'd0);
    consume(0);

    // Single-beat frame: margin against the minimum representable value.
    fr = '{32'd7};
    send_frame(1, 0, 0);
    lit("single_margin_u", 64'(out_margin_u), 64'd7);
    lit("single_margin_s", 64'(out_margin_s), 64'h0_8000_0007);
    lit("single_error", 64'(out_error_u), 64'd1);
    consume(0);

    // Overlong frame: closes at NUM_CLASSES beats with error.
    fr = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    send_frame(10, -1, 0);
    lit("overlong_error", 64'(out_error_u), 64'd1);
    lit("overlong_class", 64'(out_class_u), 64'd9);
    consume(0);

    // Backpressure: result held, beats refused.
    fr = '{32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd0, 32'd5, 32'd4, 32'd8, 32'd6};
    send_frame(10, 9, 0);
    in_valid = 1'b1; in_score = 32'd99; in_last = 1'b0;
    repeat (5) begin
      lit("hold_in_ready", 64'(in_ready_u), 64'd0);
      lit("hold_class", 64'(out_class_u), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    lit("release_valid", 64'(out_valid_u), 64'd0);
    lit("release_in_ready", 64'(in_ready_u), 64'd1);
    out_ready = 1'b0; in_valid = 1'b0;

    // Reset mid-frame discards the partial frame.
    fr = '{32'd900, 32'd800, 32'd700, 32'd600, 32'd950};
    send_frame(5, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    lit("rst_valid", 64'(out_valid_u), 64'd0);
    lit("rst_class", 64'(out_class_u), 64'hF);
    rst = 1'b0;
    fr = '{32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd0, 32'd5, 32'd4, 32'd8, 32'd6};
    send_frame(10, 9, 0);
    lit("post_rst_class", 64'(out_class_u), 64'd1);
    lit("post_rst_score", 64'(out_score_u), 64'd9);
    lit("post_rst_margin", 64'(out_margin_u), 64'd1);
    consume(0);

    // Randomized frames checked against the model.
    for (int f = 0; f < 60; f++) begin
      int kind, n, last_at, smode;
      kind = $urandom_range(0, 9);
      smode = $urandom_range(0, 2);
      if (kind < 2) begin n = $urandom_range(1, 9); last_at = n - 1; end
      else if (kind == 2) begin n = 10; last_at = -1; end
      else begin n = 10; last_at = 9; end
      fr.delete();
      for (int i = 0; i < n; i++) begin
        if (smode == 0) fr.push_back($urandom);
        else if (smode == 1) fr.push_back(W'($urandom_range(0, 7)));
        else fr.push_back(W'(int'($urandom_range(0, 7)) - 4));
      end
      send_frame(n, last_at, $urandom_range(0, 2));
      consume($urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Streaming classifier output stage for the CNN pipeline; sits after fc_layer.
- Replaces the combinational sort-and-compare on fixed prob_0..prob_9 with a sequential scan.
- Consumes one class score per beat over a valid/ready handshake and tracks the best and second-best score.
- Emits winning class index, top score and confidence margin (best minus second) once per frame, with a per-frame error flag.

Parameters:
- NUM_CLASSES, 10, classes per frame; legal range 2..256.
- SCORE_W, 32, score width in bits.
- SIGNED_MODE, 0, 1 = scores compared as two's complement, 0 = unsigned.
- IDX_W, $clog2(NUM_CLASSES+1), index width; the all-ones value is reserved as the "no result" code.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous to clk, active-high.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block accepts a beat.
- in_score  in  SCORE_W  class score; beat k of a frame is class k.
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts the result.
- out_class  out  IDX_W  winning class index.
- out_score  out  SCORE_W  winning score.
- out_margin  out  SCORE_W+1  best minus second-best, unsigned.
- out_error  out  1  frame length differed from NUM_CLASSES.

Behaviour:
- Reset state:
  - State is ACCUM; beat counter is 0; best and second are cleared.
  - in_ready=1, out_valid=0, out_class=all-ones, out_score=0, out_margin=0, out_error=0.
- State ACCUM:
  - in_ready=1. A beat is accepted when in_valid and in_ready are both high.
  - Beat 0: best=score, best_idx=0; second=minimum representable value (0 unsigned, -2^(SCORE_W-1) signed).
  - Later beats, score > best: second=best, then best=score, best_idx=count.
  - Later beats, score <= best and score > second: second=score.
  - Comparisons are strict, so on a tie the lower index wins.
  - count increments on every accepted beat.
- Frame close: the frame closes on an accepted beat that has in_last=1, or that is beat NUM_CLASSES-1.
  - Outputs are registered and out_valid rises the cycle after the closing beat. Latency is 1 cycle from the last beat to out_valid.
  - State moves to HOLD and count returns to 0.
- Error cases:
  - in_last on beat k < NUM_CLASSES-1: out_error=1; result still covers the k+1 beats.
  - Beat NUM_CLASSES-1 without in_last: out_error=1; result covers NUM_CLASSES beats; the next beat starts a new frame.
  - A single-beat frame gives margin = score - minimum value.
- Margin: computed in SCORE_W+1 bits with sign-extension in signed mode. It cannot go negative.
- State HOLD:
  - in_ready=0. Outputs stay stable while out_valid=1 and out_ready=0.
  - When out_ready=1 and out_valid=1: out_valid drops next cycle and state returns to ACCUM.
  - in_ready rises in that same next cycle; there is no same-cycle overlap of output and input.
  - out_class, out_score, out_margin and out_error keep their last values after the handshake.
- Reset mid-frame or mid-HOLD: the partial frame or pending result is discarded and all outputs return to reset values on the next edge.
- in_score and in_last are ignored whenever in_valid=0 or in_ready=0.

Decomposition:
- Shared package cnn_pkg holds:
  - NUM_CLASSES_DEFAULT=10 and SCORE_W_DEFAULT=32.
  - Helper function score_gt(a, b, signed_mode).
  - Enum argmax_state_t {ACCUM, HOLD}.
- One sub-module is natural: topk2_tracker. It is the combinational compare/update of best, second and best_idx for one beat, parametrised by SCORE_W, IDX_W and SIGNED_MODE.
- The FSM, beat counter and output registers stay in argmax_stream.

Test Plan:
- NUM_CLASSES=10, unsigned, scores 3,9,1,7,2,0,5,4,8,6 with in_last on beat 9 -> out_class=1, out_score=9, out_margin=1, out_error=0, out_valid one cycle after beat 9.
- Tie case, scores 5,12,12,0,0,0,0,0,0,0 -> out_class=1, out_margin=0.
- SIGNED_MODE=1, scores -5,-2,-9,-3,-7,-8,-6,-4,-10,-11 -> out_class=1, out_score=-2, out_margin=1.
- in_last on beat 3 with scores 4,2,6,1 -> out_error=1, out_class=2, out_margin=2. The next frame of 10 beats then completes with out_error=0.
- Hold out_ready=0 for 5 cycles after out_valid, driving in_valid=1 throughout -> in_ready=0, outputs stable, no beats consumed. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Assert rst after beat 4 of a frame -> out_valid=0 and out_class=all-ones. A fresh 10-beat frame then gives the correct result with no carry-over from the discarded frame.
